// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester arbiter for the single-port 256x8 program/data memory.
//   Requester 0 is the processor core and requester 1 is the loader/debug port.
//   The arbiter drives the memory address, write-data and write-strobe pins.
//   Ownership is sequenced by a three-state FSM (IDLE, OWN0, OWN1).
//   Fairness is round-robin, with a bounded burst length under contention.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   m0_*/m1_*             requester ports: req, write, addr, wdata in;
//                         gnt (transfer completes this cycle), rdata out
//   mem_addr/mem_wdata    memory address and write data
//   mem_write             memory write strobe (synchronous write)
//   mem_rdata             memory combinational read data
//   owner                 00=idle, 01=m0, 10=m1
module mem_arbiter #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_write,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_write,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner
);

   localparam int CNT_W = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   // The state encoding doubles as the owner code, so owner can never be 11.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic             rr_last_q, rr_last_d;     // index of the most recent owner
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

   // Current/other requester, seen from the owning state.
   logic   cur_req;
   logic   oth_req;
   logic   cur_idx;
   state_t oth_state;

   assign cur_idx   = (state_q == OWN1);
   assign cur_req   = cur_idx ? m1_req : m0_req;
   assign oth_req   = cur_idx ? m0_req : m1_req;
   assign oth_state = cur_idx ? OWN0 : OWN1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         rr_last_q   <= 1'b1;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_last_q   <= rr_last_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // Next state
   always_comb begin
      state_d     = state_q;
      rr_last_d   = rr_last_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         IDLE: begin
            burst_cnt_d = '0;
            // On a tie, m0 wins only if m1 was the last owner.
            if (m0_req && (!m1_req || rr_last_q)) state_d = OWN0;
            else if (m1_req)                      state_d = OWN1;
         end
         OWN0, OWN1: begin
            if (!cur_req) begin
               state_d     = oth_req ? oth_state : IDLE;
               burst_cnt_d = '0;
               rr_last_d   = cur_idx;
            end else if (oth_req && (burst_cnt_q == CNT_LAST)) begin
               // Forced handoff; this cycle's grant still completes.
               state_d     = oth_state;
               burst_cnt_d = '0;
               rr_last_d   = cur_idx;
            end else if (burst_cnt_q != CNT_LAST) begin
               // Saturates while uncontended, so a late contender waits at
               // most one more grant.
               burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from state alone, so they drop as soon as reset
   // clears the state register.
   always_comb begin
      owner     = state_q;
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      m0_rdata  = '0;
      m1_rdata  = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_write = 1'b0;
      case (state_q)
         OWN0: begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            m0_gnt    = m0_req;
            mem_write = m0_req & m0_write;
            m0_rdata  = mem_rdata;
         end
         OWN1: begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            m1_gnt    = m1_req;
            mem_write = m1_req & m1_write;
            m1_rdata  = mem_rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Bench for mem_arbiter with a 256x8 memory model attached to the mem_* pins.
//   Requester processes push each issued transfer into a per-requester queue.
//   A negedge monitor runs a rule-level ownership model and predicts the
//   expected grants. On each grant it pops the transfer and checks the
//   address, strobe and data against a reference memory.
module tb_mem_arbiter;
   localparam int MB = 4;

   typedef struct packed {
      logic       wr;
      logic [7:0] a;
      logic [7:0] d;
   } txn_t;

   logic            clk = 1'b0;
   logic            reset;
   logic [1:0]      req, wr;
   logic [1:0][7:0] addr, wd;
   logic            m0_gnt, m1_gnt, mem_write;
   logic [7:0]      m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]      owner;
   logic [1:0]      gnt;
   logic [7:0]      mem [256];
   logic [7:0]      ref_mem [256];

   txn_t q0[$], q1[$];
   int   recq[$];
   int   errors = 0, checks = 0;
   int   wr_cycles = 0;
   bit   sb_on = 1'b1, rec_on = 1'b0;

   assign gnt       = {m1_gnt, m0_gnt};
   assign mem_rdata = mem[mem_addr];

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MB)) dut (
      .clk(clk), .reset(reset),
      .m0_req(req[0]), .m0_write(wr[0]), .m0_addr(addr[0]), .m0_wdata(wd[0]),
      .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
      .m1_req(req[1]), .m1_write(wr[1]), .m1_addr(addr[1]), .m1_wdata(wd[1]),
      .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
      .mem_rdata(mem_rdata), .owner(owner)
   );

   function automatic logic [7:0] init_val(input int i);
      if (i == 16) return 8'h5A;
      return 8'(i * 37 + 11);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Memory: combinational read, write committed at the clock edge.
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_val(i);
      forever begin
         @(posedge clk);
         if (mem_write) mem[mem_addr] <= mem_wdata;
      end
   end

   // Monitor: ownership model plus scoreboard.
   initial begin
      int  own, cnt, last, me, other;
      bit  r [2];
      txn_t t;
      own = 0; cnt = 0; last = 1;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      forever begin
         @(negedge clk);
         if (reset) begin
            own = 0; cnt = 0; last = 1;
            chk("rst_owner", 32'(owner), 0);
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_mem_write", 32'(mem_write), 0);
            chk("rst_mem_addr", 32'(mem_addr), 0);
         end else begin
            r[0] = req[0];
            r[1] = req[1];
            chk("no_double_gnt", 32'(m0_gnt & m1_gnt), 0);
            chk("write_needs_gnt", 32'(mem_write & ~(m0_gnt | m1_gnt)), 0);
            chk("owner_not_11", 32'(owner == 2'b11), 0);
            chk("owner", 32'(owner), 32'(own));
            chk("m0_gnt", 32'(m0_gnt), 32'(own == 1 && r[0]));
            chk("m1_gnt", 32'(m1_gnt), 32'(own == 2 && r[1]));
            chk("m0_rdata_route", 32'(m0_rdata), (own == 1) ? 32'(mem_rdata) : 0);
            chk("m1_rdata_route", 32'(m1_rdata), (own == 2) ? 32'(mem_rdata) : 0);
            if (mem_write) wr_cycles++;
            if (rec_on && (m0_gnt || m1_gnt)) recq.push_back(m1_gnt ? 1 : 0);
            if (sb_on) begin
               for (int k = 0; k < 2; k++) begin
                  if (gnt[k]) begin
                     if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                        chk("sb_unexpected_gnt", 32'(k), 32'hFFFF);
                     end else begin
                        t = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk("sb_addr", 32'(mem_addr), 32'(t.a));
                        chk("sb_mem_write", 32'(mem_write), 32'(t.wr));
                        if (t.wr) begin
                           chk("sb_wdata", 32'(mem_wdata), 32'(t.d));
                           ref_mem[t.a] = t.d;
                        end else begin
                           chk("sb_rdata", 32'(k == 0 ? m0_rdata : m1_rdata), 32'(ref_mem[t.a]));
                        end
                     end
                  end
               end
            end
            // Who owns the next cycle, from the arbitration rules.
            if (own == 0) begin
               if (r[0] && r[1]) own = (last == 1) ? 1 : 2;
               else if (r[0])    own = 1;
               else if (r[1])    own = 2;
               cnt = 0;
            end else begin
               me    = own - 1;
               other = 1 - me;
               if (!r[me]) begin
                  own = r[other] ? other + 1 : 0;
                  cnt = 0; last = me;
               end else if (r[other] && cnt == MB - 1) begin
                  own = other + 1;
                  cnt = 0; last = me;
               end else if (cnt < MB - 1) begin
                  cnt++;
               end
            end
         end
      end
   end

   // Issue n transfers on requester k. rnd: random release/idle gaps and cancels.
   task automatic run_req(input int k, input int n, input bit rnd);
      txn_t t;
      int   w;
      bit   got, cancel;
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         t.wr = 1'($urandom_range(0, 1));
         t.a  = 8'($urandom_range(0, 15));
         t.d  = 8'($urandom);
         if (k == 0) q0.push_back(t); else q1.push_back(t);
         req[k] = 1'b1; wr[k] = t.wr; addr[k] = t.a; wd[k] = t.d;
         w = 0; got = 0; cancel = 0;
         while (!got && !cancel && w < 200) begin
            @(negedge clk);
            w++;
            if (gnt[k]) got = 1;
            else if (rnd && $urandom_range(0, 15) == 0) cancel = 1;
         end
         @(posedge clk); #1;
         if (!got) begin
            if (k == 0) t = q0.pop_back(); else t = q1.pop_back();
            req[k] = 1'b0;
            if (!cancel) begin
               checks++; errors++;
               $display("FAIL gnt_timeout req%0d: no grant after %0d cycles, required within 200", k, w);
            end
         end else if (i == n - 1) begin
            req[k] = 1'b0;
         end else if (rnd && $urandom_range(0, 1) == 0) begin
            req[k] = 1'b0;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         end
      end
      req[k] = 1'b0;
   endtask

   // One isolated transfer; returns the read data and the negedge count to grant.
   task automatic single(input int k, input bit w_, input logic [7:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output int lat);
      txn_t t;
      t.wr = w_; t.a = a; t.d = d;
      @(posedge clk); #1;
      if (k == 0) q0.push_back(t); else q1.push_back(t);
      req[k] = 1'b1; wr[k] = w_; addr[k] = a; wd[k] = d;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!gnt[k] && lat < 50);
      rd = (k == 0) ? m0_rdata : m1_rdata;
      @(posedge clk); #1;
      req[k] = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd;
      int lat, wc;
      reset = 1'b1; req = '0; wr = '0; addr = '0; wd = '0;
      #2;
      chk("init_rst_owner", 32'(owner), 0);
      chk("init_rst_mem_wdata", 32'(mem_wdata), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Continuous contention from IDLE: 4 grants each, alternating, m0 first.
      rec_on = 1'b1;
      fork
         run_req(0, 8, 1'b0);
         run_req(1, 8, 1'b0);
      join
      rec_on = 1'b0;
      chk("contention_len", 32'(recq.size()), 16);
      for (int i = 0; i < recq.size() && i < 16; i++)
         chk("contention_order", 32'(recq[i]), 32'((i / 4) % 2));
      repeat (3) @(posedge clk);

      // Lone m0 read of the preloaded location.
      single(0, 1'b0, 8'h10, 8'h00, rd, lat);
      chk("m0_read_data", 32'(rd), 32'h5A);
      chk("m0_read_latency", 32'(lat), 2);
      @(negedge clk);
      chk("no_gnt_after_drop", 32'(m0_gnt), 0);
      @(negedge clk);
      chk("idle_after_release", 32'(owner), 0);

      // m1 single write, then read back by m0.
      wc = wr_cycles;
      single(1, 1'b1, 8'h20, 8'hC3, rd, lat);
      chk("m1_write_latency", 32'(lat), 2);
      chk("m1_write_strobe_cycles", 32'(wr_cycles - wc), 1);
      chk("mem_20_after_write", 32'(mem[8'h20]), 32'hC3);
      single(0, 1'b0, 8'h20, 8'h00, rd, lat);
      chk("m0_read_back", 32'(rd), 32'hC3);

      // Randomized traffic with early release, streaming and cancels.
      fork
         run_req(0, 60, 1'b1);
         run_req(1, 60, 1'b1);
      join
      repeat (3) @(posedge clk);
      #1;

      // Reset in the second cycle of an m1 burst.
      sb_on = 1'b0;
      req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 8'h30; wd[1] = 8'h99;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_owner", 32'(owner), 2);
      req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 8'h10;
      #1;
      chk("pre_rst_mem_write", 32'(mem_write), 1);
      reset = 1'b1;
      #1;
      chk("async_rst_owner", 32'(owner), 0);
      chk("async_rst_gnt", 32'(gnt), 0);
      chk("async_rst_mem_write", 32'(mem_write), 0);
      chk("async_rst_mem_addr", 32'(mem_addr), 0);
      chk("async_rst_mem_wdata", 32'(mem_wdata), 0);
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      recq.delete();
      rec_on = 1'b1;
      repeat (9) @(posedge clk);
      #1;
      rec_on = 1'b0;
      req = '0;
      chk("post_rst_len", 32'(recq.size()), 8);
      for (int i = 0; i < recq.size() && i < 8; i++)
         chk("post_rst_order", 32'(recq[i]), 32'(i / 4));
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
